// File: rtl/gamepad_poller_pkg.sv
// Shared FSM state type, pad-0 NES button indices and the FF00 low-nibble mapping
// used by the gamepad_poller block.
package gamepad_poller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Selected groups are ANDed so a press in either selected group pulls its bit low.
  function automatic logic [3:0] ff00_map(input logic [7:0] pressed,
                                          input logic       sel_btn_n,
                                          input logic       sel_dir_n);
    logic [3:0] btn_s;
    logic [3:0] dir_s;
    logic [3:0] nib_s;
    btn_s = ~{pressed[BTN_START], pressed[BTN_SELECT], pressed[BTN_B], pressed[BTN_A]};
    dir_s = ~{pressed[BTN_DOWN], pressed[BTN_UP], pressed[BTN_LEFT], pressed[BTN_RIGHT]};
    nib_s = 4'hF;
    if (!sel_btn_n) nib_s = nib_s & btn_s;
    else            nib_s = nib_s;
    if (!sel_dir_n) nib_s = nib_s & dir_s;
    else            nib_s = nib_s;
    return nib_s;
  endfunction

endpackage

// File: rtl/gamepad_sync2.sv
// Two-flop synchronizer for the asynchronous, active-low pad data lines.
// Resets to all ones so an unconnected pad reads as "nothing pressed".
module gamepad_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability chain, released level on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/gamepad_poller.sv
// Serial NES/SNES pad scanner for the Game Boy joypad path: periodic latch/clock
// scan, FF00 nibble and press interrupt. Define GAMEPAD_POLLER_DEBOUNCE_EN for two-scan debounce.
module gamepad_poller
  import gamepad_poller_pkg::*;
#(
  parameter int NUM_PADS      = 2,
  parameter int NUM_BITS      = 8,
  parameter int CLK_DIV       = 6,
  parameter int STROBE_CYCLES = 12,
  parameter int POLL_PERIOD   = 69905
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         poll_enable,
  input  logic [NUM_PADS-1:0]          pad_data_in,
  output logic                         pad_latch,
  output logic                         pad_clk,
  input  logic                         sel_btn_n,
  input  logic                         sel_dir_n,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons_out,
  output logic                         buttons_valid,
  output logic [3:0]                   ff00_nibble,
  output logic                         joypad_irq,
  output logic                         busy
);

  localparam int TOT    = NUM_PADS * NUM_BITS;
  localparam int PH_MAX = (STROBE_CYCLES > CLK_DIV) ? STROBE_CYCLES : CLK_DIV;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int PC_W   = $clog2(POLL_PERIOD);
  localparam int IDX_W  = $clog2(NUM_BITS);

  state_t                              state_r, next_state_s;
  logic [PC_W-1:0]                     poll_cnt_r;
  logic [PH_W-1:0]                     ph_cnt_r;
  logic [IDX_W-1:0]                    idx_r;
  logic [NUM_PADS-1:0][NUM_BITS-1:0]   cap_r;
  logic [NUM_PADS-1:0]                 pad_sync_s;
  logic                                ph_last_s;
  logic                                latch_s, pclk_s, busy_s;
  logic                                latch_r, pclk_r, busy_r;
  logic [TOT-1:0]                      new_s, upd_s, buttons_r;
  logic [7:0]                          grp_s, rise_s;
  logic                                valid_r, irq_r;
  logic [3:0]                          ff00_r;
`ifdef GAMEPAD_POLLER_DEBOUNCE_EN
  logic [TOT-1:0]                      prev_r;
`endif

  gamepad_sync2 #(.WIDTH(NUM_PADS)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (pad_data_in),
    .q       (pad_sync_s)
  );

  // Phase terminal count for the timed states
  always_comb begin
    case (state_r)
      LATCH:     ph_last_s = (ph_cnt_r == PH_W'(STROBE_CYCLES - 1));
      LOW, HIGH: ph_last_s = (ph_cnt_r == PH_W'(CLK_DIV - 1));
      default:   ph_last_s = 1'b0;
    endcase
  end

  // State register plus registered strobe, shift clock and busy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      latch_r <= 1'b0;
      pclk_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      latch_r <= latch_s;
      pclk_r  <= pclk_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (poll_enable && (poll_cnt_r == PC_W'(POLL_PERIOD - 1))) next_state_s = LATCH;
        else                                                       next_state_s = IDLE;
      end
      LATCH: begin
        if (ph_last_s) next_state_s = LOW;
        else           next_state_s = LATCH;
      end
      LOW: begin
        if (ph_last_s) next_state_s = (idx_r == IDX_W'(NUM_BITS - 1)) ? DONE : HIGH;
        else           next_state_s = LOW;
      end
      HIGH: begin
        if (ph_last_s) next_state_s = LOW;
        else           next_state_s = HIGH;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered pins track the state exactly
  always_comb begin
    latch_s = (next_state_s == LATCH);
    pclk_s  = (next_state_s == HIGH);
    busy_s  = (next_state_s != IDLE);
  end

  // Poll interval, phase timer, bit index and serial capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt_r <= {PC_W{1'b0}};
      ph_cnt_r   <= {PH_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      cap_r      <= {TOT{1'b1}};
    end else begin
      if (state_r == IDLE && poll_enable)
        poll_cnt_r <= (poll_cnt_r == PC_W'(POLL_PERIOD - 1)) ? {PC_W{1'b0}} : poll_cnt_r + PC_W'(1);
      else
        poll_cnt_r <= poll_cnt_r;
      if (state_r == IDLE || next_state_s != state_r) ph_cnt_r <= {PH_W{1'b0}};
      else                                            ph_cnt_r <= ph_cnt_r + PH_W'(1);
      if (state_r == LATCH)                idx_r <= {IDX_W{1'b0}};
      else if (state_r == HIGH && ph_last_s) idx_r <= idx_r + IDX_W'(1);
      else                                 idx_r <= idx_r;
      for (int p = 0; p < NUM_PADS; p++) begin
        if (state_r == LOW && ph_last_s) cap_r[p][idx_r] <= pad_sync_s[p];
        else                             cap_r[p]        <= cap_r[p];
      end
    end
  end

  // Pressed view of the capture, optional debounce, and pad-0 rising presses in selected groups
  always_comb begin
    new_s = ~cap_r;
`ifdef GAMEPAD_POLLER_DEBOUNCE_EN
    upd_s = (new_s & ~(new_s ^ prev_r)) | (buttons_r & (new_s ^ prev_r));
`else
    upd_s = new_s;
`endif
    grp_s  = {{4{~sel_dir_n}}, {4{~sel_btn_n}}};
    rise_s = upd_s[7:0] & ~buttons_r[7:0] & grp_s;
  end

  // Published button vector, pulses and FF00 nibble
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buttons_r <= {TOT{1'b0}};
      valid_r   <= 1'b0;
      irq_r     <= 1'b0;
      ff00_r    <= 4'hF;
`ifdef GAMEPAD_POLLER_DEBOUNCE_EN
      prev_r    <= {TOT{1'b0}};
`endif
    end else begin
      if (state_r == DONE) begin
        buttons_r <= upd_s;
        valid_r   <= 1'b1;
        irq_r     <= |rise_s;
`ifdef GAMEPAD_POLLER_DEBOUNCE_EN
        prev_r    <= new_s;
`endif
      end else begin
        buttons_r <= buttons_r;
        valid_r   <= 1'b0;
        irq_r     <= 1'b0;
      end
      ff00_r <= ff00_map(buttons_r[7:0], sel_btn_n, sel_dir_n);
    end
  end

  assign pad_latch     = latch_r;
  assign pad_clk       = pclk_r;
  assign busy          = busy_r;
  assign buttons_out   = buttons_r;
  assign buttons_valid = valid_r;
  assign joypad_irq    = irq_r;
  assign ff00_nibble   = ff00_r;

endmodule

// File: tb/tb_gamepad_poller.sv
// Self-checking bench for gamepad_poller: behavioural shift-register pads, a scan-level
// reference model, a constant vector table, randomized scans and multi-cycle corner cases.
module tb_gamepad_poller;

  localparam int NP = 2;
  localparam int NB = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          poll_enable = 1'b1;
  logic [NP-1:0] pad_data_in;
  logic          pad_latch, pad_clk;
  logic          sel_btn_n = 1'b1;
  logic          sel_dir_n = 1'b1;
  logic [NP*NB-1:0] buttons_out;
  logic          buttons_valid;
  logic [3:0]    ff00_nibble;
  logic          joypad_irq;
  logic          busy;

  gamepad_poller #(
    .NUM_PADS(NP), .NUM_BITS(NB), .CLK_DIV(4), .STROBE_CYCLES(8), .POLL_PERIOD(200)
  ) dut (
    .clock(clock), .reset_n(reset_n), .poll_enable(poll_enable), .pad_data_in(pad_data_in),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .sel_btn_n(sel_btn_n), .sel_dir_n(sel_dir_n),
    .buttons_out(buttons_out), .buttons_valid(buttons_valid), .ff00_nibble(ff00_nibble),
    .joypad_irq(joypad_irq), .busy(busy)
  );

  always #5 clock = ~clock;

  // Pads: latch loads bit 0, each pad_clk rise advances, active-low, idle high after the last bit
  logic [7:0] pads [NP];
  int pos = 0;
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pos <= 0;
    else           pos <= pos + 1;
  end
  always_comb begin
    for (int p = 0; p < NP; p++)
      pad_data_in[p] = (pos < NB) ? ~pads[p][pos[2:0]] : 1'b1;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model state: published buttons and (debounce) previous raw scan
  logic [15:0] m_buttons = 16'h0000;
  logic [15:0] m_prev = 16'h0000;

  function automatic logic [3:0] ref_nib(input logic [7:0] b, input logic sb, input logic sd);
    logic [3:0] r;
    int dir_idx;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: dir_idx = 7;
        1: dir_idx = 6;
        2: dir_idx = 4;
        default: dir_idx = 5;
      endcase
      r[k] = !((!sb && b[k]) || (!sd && b[dir_idx]));
    end
    return r;
  endfunction

  task automatic run_scan(input string tag, output logic [15:0] got_b, output int irq_n);
    logic ok;
    logic [15:0] cur, nb;
    int exp_irq;
    ok = 1'b0;
    irq_n = 0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clock);
      if (joypad_irq) irq_n++;
      if (buttons_valid) begin
        ok = 1'b1;
        break;
      end
    end
    got_b = buttons_out;
    check({tag, "_valid"}, {31'd0, ok}, 32'd1);
    cur = {pads[1], pads[0]};
    for (int i = 0; i < 16; i++) begin
`ifdef GAMEPAD_POLLER_DEBOUNCE_EN
      nb[i] = (cur[i] == m_prev[i]) ? cur[i] : m_buttons[i];
`else
      nb[i] = cur[i];
`endif
    end
    m_prev = cur;
    exp_irq = 0;
    for (int k = 0; k < 8; k++) begin
      if (nb[k] && !m_buttons[k] && ((k < 4) ? !sel_btn_n : !sel_dir_n)) exp_irq = 1;
    end
    m_buttons = nb;
    check({tag, "_buttons"}, {16'd0, got_b}, {16'd0, nb});
    check({tag, "_irq"}, irq_n, exp_irq);
    @(negedge clock);
    check({tag, "_ff00"}, {28'd0, ff00_nibble}, {28'd0, ref_nib(nb[7:0], sel_btn_n, sel_dir_n)});
  endtask

  typedef struct {
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic        sb;
    logic        sd;
    logic [15:0] eb;
    logic [3:0]  en;
    int          ei;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [15:0] gb;
    int ni, n, latch_hi, clk_hi, clk_rise, busy_hi, rises;
    logic prev_clk, prev_latch;

    tbl[0] = '{8'h81, 8'h08, 1'b0, 1'b1, 16'h0881, 4'hE, 1};
    tbl[1] = '{8'h81, 8'h08, 1'b1, 1'b1, 16'h0881, 4'hF, 0};
    tbl[2] = '{8'h42, 8'h00, 1'b1, 1'b0, 16'h0042, 4'hD, 1};
    tbl[3] = '{8'h4A, 8'hFF, 1'b1, 1'b0, 16'hFF4A, 4'hD, 0};
    tbl[4] = '{8'h00, 8'hFF, 1'b0, 1'b0, 16'hFF00, 4'hF, 0};
    tbl[5] = '{8'h30, 8'h00, 1'b0, 1'b0, 16'h0030, 4'h3, 1};
    tbl[6] = '{8'h35, 8'h00, 1'b0, 1'b0, 16'h0035, 4'h2, 1};
    tbl[7] = '{8'h80, 8'h00, 1'b1, 1'b1, 16'h0080, 4'hF, 0};

    pads[0] = 8'h00;
    pads[1] = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_latch", {31'd0, pad_latch}, 32'd0);
    check("rst_clk", {31'd0, pad_clk}, 32'd0);
    check("rst_buttons", {16'd0, buttons_out}, 32'd0);
    check("rst_valid", {31'd0, buttons_valid}, 32'd0);
    check("rst_irq", {31'd0, joypad_irq}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ff00", {28'd0, ff00_nibble}, 32'hF);

    // First scan: timing of latch, clock phases and busy
    reset_n = 1'b1;
    n = 0;
    while (!pad_latch && n < 1000) begin
      @(negedge clock);
      n++;
    end
    check("first_latch_delay", n, 200);
    latch_hi = 0; clk_hi = 0; clk_rise = 0; busy_hi = 0; prev_clk = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!busy) break;
      latch_hi += int'(pad_latch);
      clk_hi   += int'(pad_clk);
      if (pad_clk && !prev_clk) clk_rise++;
      prev_clk = pad_clk;
      busy_hi++;
      @(negedge clock);
    end
    check("latch_high_cycles", latch_hi, 8);
    check("clk_high_cycles", clk_hi, 28);
    check("clk_rises", clk_rise, 7);
    check("busy_cycles", busy_hi, 69);
    check("scan1_valid", {31'd0, buttons_valid}, 32'd1);
    check("scan1_buttons", {16'd0, buttons_out}, 32'd0);
    @(negedge clock);
    check("scan1_ff00", {28'd0, ff00_nibble}, 32'hF);

`ifndef GAMEPAD_POLLER_DEBOUNCE_EN
    for (int t = 0; t < 8; t++) begin
      pads[0] = tbl[t].p0;
      pads[1] = tbl[t].p1;
      sel_btn_n = tbl[t].sb;
      sel_dir_n = tbl[t].sd;
      run_scan($sformatf("tbl%0d", t), gb, ni);
      check($sformatf("tbl%0d_const_buttons", t), {16'd0, gb}, {16'd0, tbl[t].eb});
      check($sformatf("tbl%0d_const_irq", t), ni, tbl[t].ei);
      check($sformatf("tbl%0d_const_ff00", t), {28'd0, ff00_nibble}, {28'd0, tbl[t].en});
    end

    // Selecting the direction group with Right already held: nibble follows, no interrupt
    sel_dir_n = 1'b0;
    @(negedge clock);
    check("seldir_ff00", {28'd0, ff00_nibble}, 32'hE);
    check("seldir_irq", {31'd0, joypad_irq}, 32'd0);
    run_scan("held_right", gb, ni);
    check("held_right_irq", ni, 0);
`else
    // One-scan glitch on B is filtered, two consecutive scans publish it
    sel_btn_n = 1'b0;
    pads[0] = 8'h02;
    run_scan("db_one", gb, ni);
    check("db_one_b1", {31'd0, gb[1]}, 32'd0);
    pads[0] = 8'h00;
    run_scan("db_rel", gb, ni);
    pads[0] = 8'h02;
    run_scan("db_two_a", gb, ni);
    check("db_two_a_b1", {31'd0, gb[1]}, 32'd0);
    run_scan("db_two_b", gb, ni);
    check("db_two_b_b1", {31'd0, gb[1]}, 32'd1);
`endif

    for (int r = 0; r < 20; r++) begin
      pads[0] = 8'($urandom_range(0, 255));
      pads[1] = 8'($urandom_range(0, 255));
      sel_btn_n = 1'($urandom_range(0, 1));
      sel_dir_n = 1'($urandom_range(0, 1));
      run_scan($sformatf("rnd%0d", r), gb, ni);
    end

    // poll_enable dropped mid-scan: scan finishes, then no further latch
    n = 0;
    while (!pad_latch && n < 400) begin
      @(negedge clock);
      n++;
    end
    check("pe_scan_started", {31'd0, pad_latch}, 32'd1);
    repeat (19) @(negedge clock);
    poll_enable = 1'b0;
    run_scan("pe_off", gb, ni);
    rises = 0;
    prev_latch = pad_latch;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (pad_latch && !prev_latch) rises++;
      prev_latch = pad_latch;
    end
    check("pe_no_latch", rises, 0);
    poll_enable = 1'b1;

    // Reset during the HIGH phase of bit 3
    pads[0] = 8'h5A;
    pads[1] = 8'hA5;
    rises = 0;
    prev_clk = pad_clk;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      if (pad_clk && !prev_clk) rises++;
      prev_clk = pad_clk;
      if (rises == 4) break;
    end
    check("mid_reset_reached_bit3", rises, 4);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_reset_clk", {31'd0, pad_clk}, 32'd0);
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_buttons", {16'd0, buttons_out}, 32'd0);
    check("mid_reset_ff00", {28'd0, ff00_nibble}, 32'hF);
    m_buttons = 16'h0000;
    m_prev = 16'h0000;
    @(negedge clock);
    reset_n = 1'b1;
    run_scan("post_reset", gb, ni);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
